// File: rtl/axi_burst_master_pkg.sv
// Shared constants for the single-burst AXI3 master.
// State codes, response codes, burst type and response ranking.
package axi_burst_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_ADDR = 3'd1;
    localparam state_t ST_RD_DATA = 3'd2;
    localparam state_t ST_WR_ADDR = 3'd3;
    localparam state_t ST_WR_DATA = 3'd4;
    localparam state_t ST_WR_RESP = 3'd5;
    localparam state_t ST_DONE    = 3'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

    // Higher code is treated as the worse outcome.
    function automatic logic [1:0] worst_resp(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI3-style bus bundle between the burst master and a slave.
// master drives address/write channels, slave drives responses.
interface axi_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4
) ();

    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;

    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;

    logic              wvalid;
    logic              wready;
    logic              wlast;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [ID_W-1:0]   wid;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;

    logic              rvalid;
    logic              rready;
    logic              rlast;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic [ID_W-1:0]   rid;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize,
               awburst, awlock, awcache, awprot,
        input  awready,
        output arvalid, arid, araddr, arlen, arsize,
               arburst, arlock, arcache, arprot,
        input  arready,
        output wvalid, wlast, wdata, wstrb, wid,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        input  rvalid, rlast, rdata, rresp, rid,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize,
               awburst, awlock, awcache, awprot,
        output awready,
        input  arvalid, arid, araddr, arlen, arsize,
               arburst, arlock, arcache, arprot,
        output arready,
        input  wvalid, wlast, wdata, wstrb, wid,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        output rvalid, rlast, rdata, rresp, rid,
        input  rready
    );

endinterface

// File: rtl/axi_burst_master.sv
// Issues one AXI INCR burst per accepted command and reports completion.
// Data channels are pass-through; only state, counter and command fields are registered.
module axi_burst_master
    import axi_burst_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [ID_W-1:0]     cmd_id,

    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,

    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,

    output logic                done,
    output logic [1:0]          done_resp,
    output logic                done_err,

    axi_burst_master_if.master  axi
);

    localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W / 8));

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        resp_q, resp_d;
    logic              err_q, err_d;

    logic in_wd, in_rd, last_cnt;

    assign in_wd    = (state_q == ST_WR_DATA);
    assign in_rd    = (state_q == ST_RD_DATA);
    assign last_cnt = (cnt_q == len_q);

    // Gate with rst so the handshake drops before the flops are even clocked.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;

    assign axi.awvalid = (state_q == ST_WR_ADDR);
    assign axi.awid    = id_q;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = AXSIZE;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;

    assign axi.arvalid = (state_q == ST_RD_ADDR);
    assign axi.arid    = id_q;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = AXSIZE;
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;

    assign axi.wvalid = in_wd && wd_valid;
    assign wd_ready   = in_wd && axi.wready;
    assign axi.wdata  = wd_data;
    assign axi.wstrb  = wd_strb;
    assign axi.wid    = id_q;
    assign axi.wlast  = in_wd && last_cnt;

    assign axi.bready = (state_q == ST_WR_RESP);

    assign axi.rready = in_rd && rd_ready;
    assign rd_valid   = in_rd && axi.rvalid;
    assign rd_data    = axi.rdata;
    assign rd_last    = in_rd && (last_cnt || axi.rlast);

    assign done      = (state_q == ST_DONE);
    assign done_resp = resp_q;
    assign done_err  = err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    cnt_d   = 4'd0;
                    resp_d  = RESP_OKAY;
                    err_d   = 1'b0;
                    state_d = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (axi.arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (axi.rvalid && rd_ready) begin
                    resp_d = worst_resp(resp_q, axi.rresp);
                    if ((axi.rlast != last_cnt) || (axi.rid != id_q))
                        err_d = 1'b1;
                    // Either our count or the slave's rlast closes the burst.
                    if (last_cnt || axi.rlast) begin
                        cnt_d   = 4'd0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_WR_ADDR: begin
                if (axi.awready) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (wd_valid && axi.wready) begin
                    if (last_cnt) begin
                        cnt_d   = 4'd0;
                        state_d = ST_WR_RESP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_WR_RESP: begin
                if (axi.bvalid) begin
                    resp_d  = axi.bresp;
                    err_d   = (axi.bid != id_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed and randomized bursts against a transaction-level slave and model.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_axi_burst_master;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [3:0]      cmd_len;
    logic [IW-1:0]   cmd_id;
    logic            wd_valid, wd_ready;
    logic [DW-1:0]   wd_data;
    logic [DW/8-1:0] wd_strb;
    logic            rd_valid, rd_ready, rd_last;
    logic [DW-1:0]   rd_data;
    logic            done, done_err;
    logic [1:0]      done_resp;

    axi_burst_master_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) axi ();

    axi_burst_master #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready),
        .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .axi(axi)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] prev_resp = 2'b00;
    logic       prev_err  = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic quiet_slave();
        axi.awready = 0; axi.arready = 0; axi.wready = 0;
        axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        axi.rvalid = 0; axi.rlast = 0; axi.rdata = 0;
        axi.rresp = 0; axi.rid = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
    endtask

    task automatic chk_addr(input logic [AW-1:0] a, input logic [3:0] l,
                            input logic [IW-1:0] id, input bit wr);
        if (wr) begin
            chk("awaddr", axi.awaddr, a);
            chk("awlen", axi.awlen, l);
            chk("awid", axi.awid, id);
            chk("awconst", {axi.awsize, axi.awburst, axi.awlock,
                            axi.awcache, axi.awprot}, {3'b100, 2'b01, 9'd0});
        end else begin
            chk("araddr", axi.araddr, a);
            chk("arlen", axi.arlen, l);
            chk("arid", axi.arid, id);
            chk("arconst", {axi.arsize, axi.arburst, axi.arlock,
                            axi.arcache, axi.arprot}, {3'b100, 2'b01, 9'd0});
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [3:0] len,
                            input logic [IW-1:0] id, input logic [1:0] bresp,
                            input logic [IW-1:0] bid, input int aw_dly,
                            input int abort_at);
        logic [DW-1:0]   wq[$];
        logic [DW/8-1:0] sq[$];
        int beat = 0, aw_wait = 0, b_wait;
        bit acc = 0, aw_ok = 0, w_fin = 0, b_ok = 0, fin = 0, aborted = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wq.push_back(rnd128());
            sq.push_back(16'($urandom));
        end
        b_wait = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            cmd_valid = 1; cmd_write = 1;
            cmd_addr = addr; cmd_len = len; cmd_id = id;
            axi.awready = !aw_ok && (aw_wait >= aw_dly);
            wd_valid = ($urandom_range(0, 3) != 0);
            wd_data  = (beat <= int'(len)) ? wq[beat] : rnd128();
            wd_strb  = (beat <= int'(len)) ? sq[beat] : 16'($urandom);
            axi.wready = ($urandom_range(0, 2) != 0);
            axi.bvalid = w_fin && !b_ok && (b_wait == 0);
            axi.bresp = bresp; axi.bid = bid;
            #1;
            if (cyc == 0) begin
                chk("held_resp", done_resp, prev_resp);
                chk("held_err", done_err, prev_err);
            end
            chk("cmd_ready", cmd_ready, !acc);
            chk("done", done, b_ok);
            if (done) begin
                chk("wr_resp", done_resp, bresp);
                chk("wr_err", done_err, bid != id);
                chk("wr_beats", beat, int'(len) + 1);
                fin = 1;
            end
            chk("awvalid", axi.awvalid, acc && !aw_ok);
            if (axi.awvalid) chk_addr(addr, len, id, 1);
            chk("arvalid", axi.arvalid, 0);
            chk("rready", axi.rready, 0);
            chk("wvalid", axi.wvalid, (aw_ok && !w_fin) ? wd_valid : 1'b0);
            chk("wd_ready", wd_ready, (aw_ok && !w_fin) ? axi.wready : 1'b0);
            chk("bready", axi.bready, w_fin && !b_ok);
            if (cmd_ready) acc = 1;
            if (axi.awvalid) begin
                if (axi.awready) aw_ok = 1;
                else aw_wait++;
            end
            if (axi.wvalid && axi.wready) begin
                chk("wdata", axi.wdata, wq[beat]);
                chk("wstrb", axi.wstrb, sq[beat]);
                chk("wlast", axi.wlast, beat == int'(len));
                chk("wid", axi.wid, id);
                if (beat == int'(len)) w_fin = 1;
                beat++;
                if (abort_at != 0 && beat == abort_at) begin
                    aborted = 1;
                    break;
                end
            end
            if (w_fin && !b_ok && axi.bready) begin
                if (axi.bvalid) b_ok = 1;
                else b_wait--;
            end
        end
        if (aborted) begin
            @(negedge clk);
            wd_valid = 1; axi.wready = 1; axi.bvalid = 1;
            #2 rst = 1;
            #1;
            chk("rst_wvalid", axi.wvalid, 0);
            chk("rst_wd_ready", wd_ready, 0);
            chk("rst_bready", axi.bready, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_done", done, 0);
            cmd_valid = 0;
            quiet_slave();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("rst_hold_done", done, 0);
                chk("rst_hold_resp", done_resp, 0);
            end
            rst = 0;
            prev_resp = 0;
            prev_err = 0;
        end else begin
            if (!fin) chk("write_timeout", 0, 1);
            prev_resp = bresp;
            prev_err = (bid != id);
        end
        quiet_slave();
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [3:0] len,
                           input logic [IW-1:0] id, input int rlast_at,
                           input logic [IW-1:0] rid, input bit toggle,
                           input bit rand_resp, input logic [1:0] fix_resp);
        logic [DW-1:0] dq[16];
        logic [1:0]    rq[16];
        int beat = 0, nexp;
        logic [1:0] exp_resp = 2'b00;
        logic exp_err;
        bit acc = 0, ar_ok = 0, r_fin = 0, fin = 0, rv = 0;
        for (int i = 0; i < 16; i++) begin
            dq[i] = rnd128();
            rq[i] = rand_resp ? 2'($urandom) : fix_resp;
        end
        nexp = ((rlast_at < int'(len)) ? rlast_at : int'(len)) + 1;
        for (int i = 0; i < nexp; i++)
            if (rq[i] > exp_resp) exp_resp = rq[i];
        exp_err = (rlast_at != int'(len)) || (rid != id);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            cmd_valid = 1; cmd_write = 0;
            cmd_addr = addr; cmd_len = len; cmd_id = id;
            rd_ready = toggle ? cyc[0] : ($urandom_range(0, 2) != 0);
            axi.arready = ($urandom_range(0, 1) != 0);
            if (ar_ok && !r_fin && !rv)
                rv = toggle || ($urandom_range(0, 3) != 0);
            axi.rvalid = rv;
            axi.rdata = dq[beat & 15];
            axi.rresp = rq[beat & 15];
            axi.rlast = (beat == rlast_at);
            axi.rid = rid;
            #1;
            if (cyc == 0) begin
                chk("held_resp", done_resp, prev_resp);
                chk("held_err", done_err, prev_err);
            end
            chk("cmd_ready", cmd_ready, !acc);
            chk("done", done, r_fin);
            if (done) begin
                chk("rd_resp", done_resp, exp_resp);
                chk("rd_err", done_err, exp_err);
                chk("rd_beats", beat, nexp);
                fin = 1;
            end
            chk("arvalid", axi.arvalid, acc && !ar_ok);
            if (axi.arvalid) chk_addr(addr, len, id, 0);
            chk("awvalid", axi.awvalid, 0);
            chk("wvalid", axi.wvalid, 0);
            chk("bready", axi.bready, 0);
            chk("rready", axi.rready, (ar_ok && !r_fin) ? rd_ready : 1'b0);
            chk("rd_valid", rd_valid, (ar_ok && !r_fin) ? axi.rvalid : 1'b0);
            if (cmd_ready) acc = 1;
            if (axi.arvalid && axi.arready) ar_ok = 1;
            if (axi.rvalid && axi.rready) begin
                chk("rd_data", rd_data, dq[beat]);
                chk("rd_last", rd_last,
                    (beat == int'(len)) || (beat == rlast_at));
                if (beat == nexp - 1) r_fin = 1;
                beat++;
                rv = 0;
            end
        end
        if (!fin) chk("read_timeout", 0, 1);
        prev_resp = exp_resp;
        prev_err = exp_err;
        quiet_slave();
    endtask

    initial begin
        rst = 1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        quiet_slave();
        repeat (3) @(negedge clk);
        cmd_valid = 1;
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_valids", {axi.awvalid, axi.arvalid, axi.wvalid,
                             axi.bready, axi.rready, rd_valid}, 0);
        chk("reset_done", {done, done_resp, done_err}, 0);
        chk("reset_regs", {axi.awaddr, axi.awlen, axi.awid}, 0);
        cmd_valid = 0;
        @(negedge clk);
        rst = 0;

        do_write(32'h1000, 4'd3, 4'd5, 2'b00, 4'd5, 2, 0);
        do_read(32'h2000, 4'd0, 4'd2, 0, 4'd2, 0, 0, 2'b10);
        do_read(32'h3000, 4'd15, 4'd7, 15, 4'd7, 1, 1, 2'b00);
        do_read(32'h4000, 4'd3, 4'd1, 1, 4'd1, 0, 0, 2'b01);
        do_write(32'h5000, 4'd1, 4'd3, 2'b11, 4'd4, 0, 0);
        do_read(32'h6000, 4'd2, 4'd9, 2, 4'd8, 0, 1, 2'b00);
        do_read(32'h6100, 4'd2, 4'd9, 16, 4'd9, 0, 0, 2'b00);

        for (int n = 0; n < 10; n++) begin
            logic [3:0] l, id;
            l = 4'($urandom);
            id = 4'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_write($urandom, l, id, 2'($urandom),
                         ($urandom_range(0, 3) == 0) ? ~id : id,
                         $urandom_range(0, 3), 0);
            else
                do_read($urandom, l, id,
                        ($urandom_range(0, 3) == 0) ?
                            $urandom_range(0, 15) : int'(l),
                        id, 0, 1, 2'b00);
        end

        do_write(32'h7000, 4'd3, 4'd6, 2'b00, 4'd6, 1, 1);
        do_read(32'h8000, 4'd0, 4'd4, 0, 4'd4, 0, 0, 2'b00);

        @(negedge clk);
        cmd_valid = 0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 128, data width; the strobe width is DATA_W/8.
REQ-003 SHALL have parameter ID_W, default 4, transaction ID width.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-007 cmd_write in 1, cmd_addr in ADDR_W, cmd_len in 4, cmd_id in ID_W: command fields; cmd_write=1 selects write, cmd_len is beats-1.
REQ-008 wd_valid in 1, wd_ready out 1, wd_data in DATA_W, wd_strb in DATA_W/8: write-data source stream.
REQ-009 rd_valid out 1, rd_ready in 1, rd_data out DATA_W, rd_last out 1: read-data sink stream.
REQ-010 done out 1, done_resp out 2, done_err out 1: completion pulse, worst response and protocol-error flag.
REQ-011 The write-address group SHALL be awvalid, awid, awaddr, awlen(4), awsize(3), awburst(2), awlock(2), awcache(4), awprot(3) as outputs and awready as input; araddr and the other read-address outputs SHALL mirror this group with arready as input.
REQ-012 The write-data group SHALL be wvalid, wlast, wdata, wstrb and wid as outputs and wready as input; bvalid, bresp(2) and bid SHALL be inputs and bready an output.
REQ-013 The read-data group SHALL be rvalid, rlast, rdata, rresp(2) and rid as inputs and rready as an output.

Function
REQ-014 The FSM SHALL have the states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP and DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready and its fields are registered.
REQ-016 An accepted read SHALL go to RD_ADDR and an accepted write to WR_ADDR; the address valid SHALL assert in the cycle after acceptance.
REQ-017 awvalid and arvalid, with their payload, SHALL stay stable until the ready handshake; RD_ADDR then goes to RD_DATA and WR_ADDR goes to WR_DATA.
REQ-018 The address constants SHALL be: awsize/arsize = log2(DATA_W/8) (3'b100 at 128), awburst/arburst = INCR 2'b01, and lock, cache and prot all 0.
REQ-019 In WR_DATA: wvalid=wd_valid, wd_ready=wready, wdata/wstrb pass through, and wid equals the registered ID.
REQ-020 A 4-bit beat counter SHALL count W handshakes; wlast=1 only when the count equals cmd_len, and the last handshake goes to WR_RESP.
REQ-021 In WR_RESP, bready SHALL be 1; on bvalid, done_resp=bresp and done_err=(bid!=ID), then the FSM goes to DONE.
REQ-022 In RD_DATA: rready=rd_ready, rd_valid=rvalid, rd_data=rdata; done_resp accumulates max(rresp).
REQ-023 rd_last SHALL be asserted on the beat where count==cmd_len or rlast=1, and that beat terminates to DONE.
REQ-024 done_err SHALL be set if rlast disagrees with count==cmd_len or if rid!=ID.
REQ-025 Outside RD_DATA, rready=0; outside WR_RESP, bready=0; outside WR_DATA, wvalid=0 and wd_ready=0; stray beats are not acknowledged.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE; the earliest next accept is the cycle after done.
REQ-027 done_resp and done_err SHALL hold until the next accept and then clear to 0.

Reset
REQ-028 On rst=1, outputs SHALL immediately go to: state IDLE, every valid/ready output 0, cmd_ready 0, counter 0, done/done_resp/done_err 0, registered address/len/ID 0.
REQ-029 A reset mid-transaction SHALL abort it with no done; after release the block accepts a new command normally.

Structure
REQ-030 A package axi_burst_pkg SHALL hold the state enum, the response codes (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11), the INCR constant and a worst-response function.
REQ-031 No sub-module is needed; the block is a single FSM plus counter.

Verification
REQ-032 Write of 4 beats (cmd_len=3, addr 0x1000, id 5), awready delayed 2 cycles, bresp 00 -> 4 W beats, wlast only on beat 4, wid=5, done=1 for one cycle, done_resp=00.
REQ-033 Read of 1 beat (cmd_len=0, addr 0x2000), rresp 10, rlast=1 -> one rd beat with rd_last=1, done_resp=10, done_err=0.
REQ-034 Read of 16 beats (cmd_len=15), rd_ready toggling every cycle -> rready mirrors rd_ready, 16 in-order beats, rd_last only on beat 16.
REQ-035 Read with cmd_len=3 where the slave asserts rlast on beat 2 -> rd_last on beat 2, done_err=1, FSM returns to IDLE.
REQ-036 rst asserted during write beat 2 -> wvalid/bready 0 without waiting for clk, no done; after release a read of 1 beat completes with done=1.
REQ-037 cmd_valid held high while busy -> cmd_ready=0 until the cycle after done; the second command is then accepted.
